// File: rtl/shared_mem_pkg.sv
// Shared types and constants for the shared main-memory controller.
//   mem_state_t : controller FSM states (IDLE -> WAIT -> RESP -> IDLE)
//   mem_req_t   : one request as seen on the upstream port (32-bit address and data)
//   WORD_OFF    : byte-offset bits below the word index
//   max_u       : larger of two unsigned values, used for counter sizing
package shared_mem_pkg;

  localparam int unsigned WORD_OFF   = 2;
  localparam int unsigned REQ_ADDR_W = 32;
  localparam int unsigned REQ_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } mem_state_t;

  typedef struct packed {
    logic                  we;
    logic                  core;
    logic [REQ_ADDR_W-1:0] addr;
    logic [REQ_DATA_W-1:0] wdata;
  } mem_req_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/shared_mem_ctrl_mem_array.sv
// Single-port synchronous RAM, DEPTH words of DATA_W bits.
//   clk_i   : clock
//   we_i    : write enable (write wins if both enables are set)
//   re_i    : read enable; rdata_o updates one edge later and holds otherwise
//   addr_i  : word index
//   wdata_i : write data
//   rdata_o : registered read data
// Contents and the read register are not reset.
module mem_array #(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [IDX_W-1:0]  addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/shared_mem_ctrl.sv
// Shared main-memory controller: one outstanding read or write-back from
// either core, fixed per-operation latency, valid/ready on both sides.
//   clk, reset            : clock, synchronous active-high reset
//   req_valid/req_ready   : request handshake
//   req_we, req_core      : write-back flag, originating core id
//   req_addr, req_wdata   : byte address, write data
//   resp_valid/resp_ready : response handshake
//   resp_core, resp_we    : core id and write-ack flag of the request
//   resp_rdata            : read data (0 on write ack or error)
//   resp_err              : misaligned or out-of-range address
//   busy                  : controller not idle
module shared_mem_ctrl
  import shared_mem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned RD_LATENCY  = 4,
  parameter int unsigned WR_LATENCY  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic              req_core,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_core,
  output logic              resp_we,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              busy
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = $clog2(max_u(RD_LATENCY, WR_LATENCY)) + 1;

  mem_state_t        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              req_ready_q;
  logic              resp_valid_q;
  logic              resp_core_q;
  logic              resp_we_q;
  logic              resp_err_q;
  logic              rd_ok_q;
  logic              busy_q;

  logic              acc;
  logic              addr_err;
  logic [IDX_W-1:0]  word_idx;
  logic              ram_we;
  logic              ram_re;
  logic [DATA_W-1:0] ram_rdata;
  logic [CNT_W-1:0]  lat_m1;

  assign acc      = req_valid & req_ready_q;
  assign word_idx = req_addr[WORD_OFF +: IDX_W];
  assign addr_err = (req_addr[WORD_OFF-1:0] != '0) ||
                    (req_addr[ADDR_W-1:WORD_OFF+IDX_W] != '0);
  assign ram_we   = acc & req_we & ~addr_err;
  assign ram_re   = acc & ~req_we & ~addr_err;
  assign lat_m1   = req_we ? CNT_W'(WR_LATENCY - 1) : CNT_W'(RD_LATENCY - 1);

  mem_array #(
    .DEPTH  (DEPTH_WORDS),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .addr_i  (word_idx),
    .wdata_i (req_wdata),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_core_q  <= 1'b0;
      resp_we_q    <= 1'b0;
      resp_err_q   <= 1'b0;
      rd_ok_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (acc) begin
            resp_core_q <= req_core;
            resp_we_q   <= req_we;
            resp_err_q  <= addr_err;
            rd_ok_q     <= ram_re;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if (lat_m1 == '0) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              cnt_q        <= '0;
            end else begin
              state_q <= WAIT;
              cnt_q   <= lat_m1;
            end
          end
        end
        WAIT: begin
          if (cnt_q == CNT_W'(1)) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            cnt_q        <= '0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        RESP: begin
          if (resp_ready) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            rd_ok_q      <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // The RAM read register is only reloaded on an accepted read, so it doubles
  // as the response data register; rd_ok_q zeroes it for acks, errors and reset.
  assign resp_rdata = rd_ok_q ? ram_rdata : '0;
  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_core  = resp_core_q;
  assign resp_we    = resp_we_q;
  assign resp_err   = resp_err_q;
  assign busy       = busy_q;

endmodule
